poly_horner_pipe: RTL
=====================

Name: poly_horner_pipe

Overview:
- Fully pipelined Horner polynomial evaluator: one sample per clock, one pipeline stage per Horner step.
- Generalises the fixed 5th-order ln(1+x) approximator with parametrised order, width and fractional scaling.
- Adds run-time loadable coefficient sets, with a per-sample set select, so one instance can evaluate ln, exp, sqrt or similar.
- Sits in the arithmetic function library, feeding datapath blocks that need elementary functions at full sample rate.

Parameters:
- N, 5, polynomial order; the block holds N+1 coefficients per set.
- W, 17, data MSB index; all data words are W+1 bits signed.
- FRAC, 16, fractional bits of x and of every coefficient (Q format).
- NSET, 2, number of coefficient sets.
- SW, 1, set-index width, equal to ceil(log2(NSET)).
- IW, 3, coefficient-index width, equal to ceil(log2(N+1)).
- SAT, 1, 1 = saturate each stage sum, 0 = two's-complement wrap.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- x_in  in  W+1  signed sample, Q(FRAC).
- valid_in  in  1  x_in/set_in qualifier.
- set_in  in  SW  coefficient set for this sample.
- coef_we  in  1  coefficient write strobe.
- coef_set  in  SW  set addressed by the write.
- coef_idx  in  IW  coefficient index 0..N.
- coef_data  in  W+1  signed coefficient, Q(FRAC).
- f_out  out  W+1  signed result, registered.
- valid_out  out  1  f_out qualifier.
- sat_out  out  1  1 if any stage saturated for this sample.

Behaviour:
- Reset (reset=0, asynchronous):
  - f_out=0, valid_out=0, sat_out=0, all pipeline valids=0.
  - Set 0 loads p0..p5 = 1, 65481, -32093, 18601, -8517, 1954.
  - All other sets load 0.
  - When N≠5, set 0 loads p0=1 and all other coefficients 0.
- Coefficient write: on a clock edge with coef_we=1 and coef_idx≤N, coef[coef_set][coef_idx] takes coef_data. The new value is visible to stage reads from the next cycle. Writes with coef_idx>N or coef_set≥NSET are ignored.
- Stage 0 (input register): captures x, set_in, valid_in, with s=coef[set][N].
- Stage j=1..N, k=N-j:
  - Product: prod = x*s, full 2W+2 bits, no rounding.
  - Sum: s' = (prod >>> FRAC) + coef[set][k], computed at W+2 bits.
  - Overflow (SAT=1): clip s' to [-2^W, 2^W-1] and set the stage sat flag.
  - Overflow (SAT=0): truncate s' to W+1 bits; the sat flag stays 0.
  - Registers pass forward x, set, valid and the OR of the sat flags.
- Output register: f_out=s0, valid_out, sat_out. Latency from valid_in to valid_out is N+2 clocks. Throughput is 1 sample/clock.
- Bubbles: stages with valid=0 still clock data, but the zero valid is carried through. f_out holds its last valid value when valid_out=0; it updates only on valid stages.
- Coefficient write during flight: each stage reads the live coefficient in the cycle it processes, so in-flight samples use new values only in stages they have not yet passed. This is deterministic and not an error.
- Reset mid-stream: all in-flight samples are discarded, no valid_out is produced for them, and the coefficients return to their defaults.
- Simultaneous write and read of the same coefficient in the same cycle: the stage uses the old value.

Decomposition:
- Shared package (poly_pkg): the default ln coefficient constants, the index/set width functions (clog2), and the saturate function.
- One natural sub-module, horner_stage: a registered multiply-shift-add-saturate step, instantiated N times with a generate loop.
- The coefficient bank stays in the top module.

Test Plan:
- Reset, then valid_in=1, set 0, x_in=0 → after 7 clocks f_out=1, valid_out=1, sat_out=0.
- Default set, x_in=65536 (1.0) → f_out=45427. x_in=32768 (0.5) → f_out=26572. Back-to-back inputs give results on consecutive cycles.
- Load set 1 with p0=65536 and p1..p5=0, then alternate sets per sample with x=32768 → outputs alternate 26572 and 65536 in input order.
- SAT=1, set 1 with p0=131071 and p1=65536, x_in=65536 → f_out=131071, sat_out=1. With SAT=0 the result wraps: f_out=-65537 as 18-bit, sat_out=0.
- Stream 4 samples with a valid gap, and assert reset during the 3rd cycle → valid_out stays 0 for every pre-reset sample, and set 0 reads the defaults afterward.
- Write coef[0][5]=0 while a sample is at stage 2 → that sample's result still uses 1954, and the next sample uses 0.

Source files
------------

// File: rtl/poly_pkg.sv
// -----------------------------------------------------------------------------
// poly_pkg
// Shared definitions for the Horner polynomial pipeline:
//   - default ln(1+x) coefficient table (5th order, Q16)
//   - poly_clog2      : index/set width helper (never returns less than 1)
//   - default_coef    : reset value of coefficient [set][k] for a given order
//   - sat_clip        : clip a signed value to a (msb+1)-bit signed range
// No ports (package).
// -----------------------------------------------------------------------------
package poly_pkg;

    typedef struct packed {
        logic signed [63:0] val;
        logic               ovf;
    } sat_t;

    localparam int LN_ORDER = 5;

    // ln(1+x) ~ p0 + p1*x + ... + p5*x^5, Q16
    localparam logic signed [63:0] LN_COEF [0:5] = '{
        64'sd1, 64'sd65481, -64'sd32093, 64'sd18601, -64'sd8517, 64'sd1954
    };

    function automatic int poly_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

    function automatic logic signed [63:0] default_coef(input int n, input int set, input int k);
        if (set != 0) return '0;
        if (n == LN_ORDER) return LN_COEF[k];
        return (k == 0) ? 64'sd1 : 64'sd0;
    endfunction

    function automatic sat_t sat_clip(input logic signed [63:0] v, input int msb);
        sat_t               r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi    = (64'sd1 <<< msb) - 64'sd1;
        lo    = -(64'sd1 <<< msb);
        r.val = v;
        r.ovf = 1'b0;
        if (v > hi) begin
            r.val = hi;
            r.ovf = 1'b1;
        end else if (v < lo) begin
            r.val = lo;
            r.ovf = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/horner_stage.sv
// -----------------------------------------------------------------------------
// horner_stage
// One registered Horner step: s_o = sat((x_i * s_i) >>> FRAC + coef_i).
// x, set and valid are forwarded; the sat flag accumulates along the pipe.
// Ports:
//   clk_i, rst_ni     clock, async active-low reset
//   x_i/x_o           sample (Q FRAC), passed forward
//   set_i/set_o       coefficient set of the sample, passed forward
//   valid_i/valid_o   sample qualifier, passed forward
//   s_i/s_o           running Horner sum in / out
//   sat_i/sat_o       sticky saturation flag in / out
//   coef_i            live coefficient for this step (selected by the top)
// -----------------------------------------------------------------------------
module horner_stage
    import poly_pkg::*;
#(
    parameter int W    = 17,
    parameter int FRAC = 16,
    parameter int SW   = 1,
    parameter int SAT  = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic signed [W:0]   x_i,
    input  logic [SW-1:0]       set_i,
    input  logic                valid_i,
    input  logic signed [W:0]   s_i,
    input  logic                sat_i,
    input  logic signed [W:0]   coef_i,
    output logic signed [W:0]   x_o,
    output logic [SW-1:0]       set_o,
    output logic                valid_o,
    output logic signed [W:0]   s_o,
    output logic                sat_o
);

    logic signed [2*W+1:0] prod;
    logic signed [2*W+1:0] prod_sh;
    logic signed [W+1:0]   sum;
    sat_t                  clip;
    logic signed [W:0]     s_d;
    logic                  sat_d;

    logic signed [W:0]     x_q;
    logic [SW-1:0]         set_q;
    logic                  valid_q;
    logic signed [W:0]     s_q;
    logic                  sat_q;

    always_comb begin
        prod    = (2*W+2)'(x_i) * (2*W+2)'(s_i);
        prod_sh = prod >>> FRAC;
        // sum is one bit wider than the data word so overflow is detectable
        sum     = (W+2)'(prod_sh) + (W+2)'(coef_i);
        clip    = sat_clip(64'(sum), W);
        if (SAT != 0) begin
            s_d   = clip.val[W:0];
            sat_d = sat_i | clip.ovf;
        end else begin
            s_d   = sum[W:0];
            sat_d = sat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q     <= '0;
            set_q   <= '0;
            valid_q <= 1'b0;
            s_q     <= '0;
            sat_q   <= 1'b0;
        end else begin
            x_q     <= x_i;
            set_q   <= set_i;
            valid_q <= valid_i;
            s_q     <= s_d;
            sat_q   <= sat_d;
        end
    end

    assign x_o     = x_q;
    assign set_o   = set_q;
    assign valid_o = valid_q;
    assign s_o     = s_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/poly_horner_pipe.sv
// -----------------------------------------------------------------------------
// poly_horner_pipe
// Fully pipelined Horner evaluator, one sample per clock, latency N+2.
// Holds NSET run-time writable coefficient sets; each sample selects a set.
// Ports:
//   clk        rising-edge clock
//   reset      async active-low reset (also restores default coefficients)
//   x_in       signed sample Q(FRAC);   valid_in qualifies x_in/set_in
//   set_in     coefficient set for the sample
//   coef_we    coefficient write strobe; coef_set/coef_idx address it,
//              coef_data is the signed Q(FRAC) value
//   f_out      registered result, held while valid_out=0
//   valid_out  f_out qualifier;  sat_out: some stage saturated this sample
// -----------------------------------------------------------------------------
module poly_horner_pipe
    import poly_pkg::*;
#(
    parameter int N    = 5,
    parameter int W    = 17,
    parameter int FRAC = 16,
    parameter int NSET = 2,
    parameter int SW   = poly_clog2(NSET),
    parameter int IW   = poly_clog2(N + 1),
    parameter int SAT  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W:0]   x_in,
    input  logic                valid_in,
    input  logic [SW-1:0]       set_in,
    input  logic                coef_we,
    input  logic [SW-1:0]       coef_set,
    input  logic [IW-1:0]       coef_idx,
    input  logic signed [W:0]   coef_data,
    output logic signed [W:0]   f_out,
    output logic                valid_out,
    output logic                sat_out
);

    // Coefficient bank; out-of-range writes simply match no entry
    logic signed [W:0] coef_q [NSET][N+1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned s = 0; s < NSET; s++) begin
                for (int unsigned k = 0; k <= N; k++) begin
                    coef_q[s][k] <= (W+1)'(default_coef(N, int'(s), int'(k)));
                end
            end
        end else if (coef_we) begin
            for (int unsigned s = 0; s < NSET; s++) begin
                for (int unsigned k = 0; k <= N; k++) begin
                    if (coef_set == SW'(s) && coef_idx == IW'(k)) begin
                        coef_q[s][k] <= coef_data;
                    end
                end
            end
        end
    end

    // Stage 0: input register, seeds the sum with the leading coefficient
    logic signed [W:0] x0_q;
    logic [SW-1:0]     set0_q;
    logic              v0_q;
    logic signed [W:0] s0_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x0_q   <= '0;
            set0_q <= '0;
            v0_q   <= 1'b0;
            s0_q   <= '0;
        end else begin
            x0_q   <= x_in;
            set0_q <= set_in;
            v0_q   <= valid_in;
            s0_q   <= coef_q[set_in][N];
        end
    end

    // Pipeline chain: index 0 is the input register, index j is stage j
    logic signed [W:0] x_c   [N+1];
    logic [SW-1:0]     set_c [N+1];
    logic              v_c   [N+1];
    logic signed [W:0] s_c   [N+1];
    logic              sat_c [N+1];

    assign x_c[0]   = x0_q;
    assign set_c[0] = set0_q;
    assign v_c[0]   = v0_q;
    assign s_c[0]   = s0_q;
    assign sat_c[0] = 1'b0;

    for (genvar j = 1; j <= N; j++) begin : g_stage
        horner_stage #(
            .W    (W),
            .FRAC (FRAC),
            .SW   (SW),
            .SAT  (SAT)
        ) u_stage (
            .clk_i   (clk),
            .rst_ni  (reset),
            .x_i     (x_c[j-1]),
            .set_i   (set_c[j-1]),
            .valid_i (v_c[j-1]),
            .s_i     (s_c[j-1]),
            .sat_i   (sat_c[j-1]),
            .coef_i  (coef_q[set_c[j-1]][N-j]),
            .x_o     (x_c[j]),
            .set_o   (set_c[j]),
            .valid_o (v_c[j]),
            .s_o     (s_c[j]),
            .sat_o   (sat_c[j])
        );
    end

    // Output register: result and flag only advance on valid samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_out     <= '0;
            valid_out <= 1'b0;
            sat_out   <= 1'b0;
        end else begin
            valid_out <= v_c[N];
            if (v_c[N]) begin
                f_out   <= s_c[N];
                sat_out <= sat_c[N];
            end
        end
    end

endmodule
